// File: rtl/delayf_tap_ctrl.sv
// delayf_tap_ctrl: command sequencer for a bank of DELAYF-style delay cells.
// Drives per-cell LOADN/MOVE/DIRECTION, watches CFLAG, and keeps a shadow
// tap count per channel. Supports load, single-step inc/dec and absolute set.
module delayf_tap_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int TAP_W     = 7,
    parameter int INIT_TAP  = 0,
    parameter int MOVE_HOLD = 2,
    parameter int MOVE_GAP  = 2,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CW-1:0]             cmd_chan,
    input  logic [1:0]                cmd_op,
    input  logic [TAP_W-1:0]          cmd_value,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [CHANNELS*TAP_W-1:0] tap_value,
    output logic [CHANNELS-1:0]       loadn,
    output logic [CHANNELS-1:0]       move,
    output logic [CHANNELS-1:0]       direction,
    input  logic [CHANNELS-1:0]       cflag
);

    localparam int IW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(MOVE_HOLD);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(MOVE_GAP);
    localparam logic [TAP_W-1:0] MAX_TAP = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] INIT_V  = TAP_W'(INIT_TAP);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_MOVE_HI,
        S_MOVE_LO,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]    chan_q;
    logic [TAP_W-1:0] target_q;
    logic [TAP_W-1:0] taps [CHANNELS];

    logic [IW-1:0]    cmd_idx;
    logic             cmd_bad;
    logic [TAP_W-1:0] cur_tap;

    // Decode the incoming channel: index into the bank and out-of-range flag.
    always_comb begin
        cmd_idx = cmd_chan[IW-1:0];
        cmd_bad = (int'(cmd_chan) >= CHANNELS);
        cur_tap = taps[cmd_idx];
    end

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_tap
        assign tap_value[g*TAP_W +: TAP_W] = taps[g];
    end

    // Sequencer: state, pulse counters, shadow taps and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            cnt       <= '0;
            chan_q    <= '0;
            target_q  <= '0;
            loadn     <= '1;
            move      <= '0;
            direction <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                taps[i] <= INIT_V;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // Pulse every LOADN low so the cells match the shadow taps.
                S_INIT: begin
                    if (cnt < HOLD_C) begin
                        loadn <= '0;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        loadn     <= '1;
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        chan_q    <= cmd_idx;
                        cnt       <= CNT_W'(1);
                        if (cmd_bad) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            case (cmd_op)
                                OP_LOAD: begin
                                    loadn[cmd_idx] <= 1'b0;
                                    state          <= S_LOAD;
                                end
                                OP_INC: begin
                                    if (cur_tap == MAX_TAP) begin
                                        done  <= 1'b1;
                                        err   <= 1'b1;
                                        state <= S_DONE;
                                    end else begin
                                        target_q           <= cur_tap + 1'b1;
                                        direction[cmd_idx] <= 1'b0;
                                        state              <= S_SETUP;
                                    end
                                end
                                OP_DEC: begin
                                    if (cur_tap == '0) begin
                                        done  <= 1'b1;
                                        err   <= 1'b1;
                                        state <= S_DONE;
                                    end else begin
                                        target_q           <= cur_tap - 1'b1;
                                        direction[cmd_idx] <= 1'b1;
                                        state              <= S_SETUP;
                                    end
                                end
                                default: begin
                                    // Setting the tap it already holds is a clean no-op.
                                    if (cmd_value == cur_tap) begin
                                        done  <= 1'b1;
                                        state <= S_DONE;
                                    end else begin
                                        target_q           <= cmd_value;
                                        direction[cmd_idx] <= (cmd_value < cur_tap);
                                        state              <= S_SETUP;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt < HOLD_C) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        loadn[chan_q] <= 1'b1;
                        taps[chan_q]  <= INIT_V;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                // Direction settled for one cycle before the first MOVE edge.
                S_SETUP: begin
                    move[chan_q] <= 1'b1;
                    cnt          <= CNT_W'(1);
                    state        <= S_MOVE_HI;
                end
                S_MOVE_HI: begin
                    if (cnt < HOLD_C) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        // The cell steps on the MOVE falling edge; track it here.
                        move[chan_q] <= 1'b0;
                        taps[chan_q] <= direction[chan_q] ? taps[chan_q] - 1'b1
                                                          : taps[chan_q] + 1'b1;
                        cnt          <= CNT_W'(1);
                        state        <= S_MOVE_LO;
                    end
                end
                S_MOVE_LO: begin
                    if (cnt < GAP_C) begin
                        cnt <= cnt + 1'b1;
                    end else if (cflag[chan_q]) begin
                        direction <= '0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        state     <= S_DONE;
                    end else if (taps[chan_q] != target_q) begin
                        move[chan_q] <= 1'b1;
                        cnt          <= CNT_W'(1);
                        state        <= S_MOVE_HI;
                    end else begin
                        direction <= '0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delayf_tap_ctrl.sv
// tb_delayf_tap_ctrl: randomized bench with a cycle-timeline reference model
// for delayf_tap_ctrl, plus directed scenarios with literal expectations.
module tb_delayf_tap_ctrl;

    localparam int CH   = 4;
    localparam int TW   = 7;
    localparam int INIT = 0;
    localparam int H    = 2;
    localparam int G    = 2;
    localparam int CWB  = 3;
    localparam int P    = H + G;
    localparam int MAXT = (1 << TW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CWB-1:0]  cmd_chan;
    logic [1:0]      cmd_op;
    logic [TW-1:0]   cmd_value;
    logic            done;
    logic            err;
    logic            busy;
    logic [CH*TW-1:0] tap_value;
    logic [CH-1:0]   loadn;
    logic [CH-1:0]   move;
    logic [CH-1:0]   direction;
    logic [CH-1:0]   cflag;

    delayf_tap_ctrl #(
        .CHANNELS (CH),
        .TAP_W    (TW),
        .INIT_TAP (INIT),
        .MOVE_HOLD(H),
        .MOVE_GAP (G),
        .CW       (CWB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_chan (cmd_chan),
        .cmd_op   (cmd_op),
        .cmd_value(cmd_value),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .tap_value(tap_value),
        .loadn    (loadn),
        .move     (move),
        .direction(direction),
        .cflag    (cflag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit            exp_en = 1'b0;
    logic [CH-1:0] e_loadn, e_move, e_dir;
    logic          e_done, e_err, e_ready;
    logic [TW-1:0] e_tap [CH];
    logic [CH*TW-1:0] pk_exp;

    int obs_pulses, obs_rise1, obs_rise2, obs_done_k;
    logic obs_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Single compare process: every enabled cycle, all outputs against the model.
    always @(negedge clk) begin
        if (exp_en) begin
            for (int i = 0; i < CH; i++) pk_exp[i*TW +: TW] = e_tap[i];
            chk("loadn", 64'(loadn), 64'(e_loadn));
            chk("move", 64'(move), 64'(e_move));
            chk("direction", 64'(direction), 64'(e_dir));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(e_err));
            chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
            chk("busy", 64'(busy), 64'(!e_ready));
            chk("tap_value", 64'(tap_value), 64'(pk_exp));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_chan  = CWB'($urandom);
        cmd_op    = 2'($urandom);
        cmd_value = TW'($urandom);
    endtask

    task automatic set_idle_exp();
        e_loadn = '1; e_move = '0; e_dir = '0;
        e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            cmd_valid = 1'b0;
            cflag = CH'($urandom);
            set_idle_exp();
        end
    endtask

    // Reset for n cycles, then the INIT reload: LOADN low H cycles, then idle.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            step();
            junk();
            cflag = CH'($urandom);
            exp_en = 1'b1;
            e_loadn = '1; e_move = '0; e_dir = '0;
            e_done = 1'b0; e_err = 1'b0; e_ready = 1'b0;
            for (int i = 0; i < CH; i++) e_tap[i] = TW'(INIT);
        end
        rst = 1'b0;
        for (int k = 1; k <= H; k++) begin
            step();
            junk();
            cflag = CH'($urandom);
            e_loadn = '0;
        end
        step();
        cmd_valid = 1'b0;
        set_idle_exp();
    endtask

    // Issue one command in the current (idle) cycle and follow its timeline.
    task automatic run_cmd(input int ch, input int op, input int val,
                           input int abort_after, input int rst_at);
        int  s, tgt, nsteps, n, done_k, kind, edges;
        bit  d, aborted, e_flag, bad;
        logic prev_mv;
        bad = (ch >= CH);
        s = bad ? 0 : int'(e_tap[ch]);
        kind = 0; e_flag = 1'b1; tgt = s; d = 1'b0; n = 0; aborted = 1'b0; nsteps = 0;
        if (!bad) begin
            case (op)
                0: kind = 1;
                1: if (s != MAXT) begin kind = 2; tgt = s + 1; end
                2: if (s != 0) begin kind = 2; tgt = s - 1; end
                default: if (val == s) e_flag = 1'b0; else begin kind = 2; tgt = val; end
            endcase
        end
        if (kind == 2) begin
            d = (tgt < s);
            nsteps = d ? s - tgt : tgt - s;
            aborted = (abort_after > 0) && (abort_after <= nsteps);
            n = aborted ? abort_after : nsteps;
            done_k = 2 + P * n;
        end else if (kind == 1) begin
            done_k = H + 1;
        end else begin
            done_k = 1;
        end
        cmd_valid = 1'b1;
        cmd_chan  = CWB'(ch);
        cmd_op    = 2'(op);
        cmd_value = TW'(val);
        obs_pulses = 0; obs_rise1 = -1; obs_rise2 = -1; obs_done_k = -1; obs_err = 1'b0;
        prev_mv = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            step();
            if (k <= done_k) junk(); else cmd_valid = 1'b0;
            cflag = CH'($urandom);
            e_loadn = '1; e_move = '0; e_dir = '0;
            e_done  = (k == done_k);
            e_err   = (k == done_k) && ((kind == 2) ? aborted : (kind == 0 && e_flag));
            e_ready = (k == done_k + 1);
            if (kind == 1) begin
                if (k <= H) e_loadn[ch] = 1'b0;
                if (k >= H + 1) e_tap[ch] = TW'(INIT);
            end
            if (kind == 2) begin
                if (k < done_k) e_dir[ch] = d;
                if (k >= 2 && k < done_k && ((k - 2) % P) < H) e_move[ch] = 1'b1;
                edges = (k >= 2 + H) ? (k - 2 - H) / P + 1 : 0;
                if (edges > n) edges = n;
                e_tap[ch] = TW'(d ? s - edges : s + edges);
                // CFLAG only matters on the last low cycle of each pulse.
                if (k >= 2 && ((k - 1) % P) == 0)
                    cflag[ch] = aborted && ((k - 1) / P == abort_after);
            end
            if (!bad) begin
                if (move[ch] === 1'b1 && !prev_mv) begin
                    obs_pulses++;
                    if (obs_rise1 < 0) obs_rise1 = k;
                    else if (obs_rise2 < 0) obs_rise2 = k;
                end
                prev_mv = move[ch];
            end
            if (done === 1'b1) begin
                obs_done_k = k;
                obs_err = err;
            end
            if (k == rst_at) begin
                do_reset(2);
                return;
            end
        end
    endtask

    initial begin
        int ch, op, val, cur, ab, ra;
        rst = 1'b1; cmd_valid = 1'b0; cmd_chan = '0; cmd_op = '0; cmd_value = '0; cflag = '0;
        for (int i = 0; i < CH; i++) e_tap[i] = TW'(INIT);
        set_idle_exp();

        do_reset(3);
        chk("reset_taps_lit", 64'(tap_value), 64'd0);
        chk("reset_ready_lit", 64'(cmd_ready), 64'd1);
        idle(2);

        run_cmd(2, 1, 0, 0, -1);
        chk("inc_done_lat", 64'(obs_done_k), 64'd6);
        chk("inc_rise", 64'(obs_rise1), 64'd2);
        chk("inc_err", 64'(obs_err), 64'd0);
        chk("inc_tap2", 64'(tap_value[20:14]), 64'd1);
        idle(1);

        run_cmd(0, 2, 0, 0, -1);
        chk("dec0_lat", 64'(obs_done_k), 64'd1);
        chk("dec0_err", 64'(obs_err), 64'd1);
        chk("dec0_pulses", 64'(obs_pulses), 64'd0);

        run_cmd(1, 3, 127, 0, -1);
        chk("set127_tap", 64'(tap_value[13:7]), 64'd127);
        run_cmd(1, 1, 0, 0, -1);
        chk("inc_sat_err", 64'(obs_err), 64'd1);
        chk("inc_sat_lat", 64'(obs_done_k), 64'd1);
        run_cmd(5, 1, 0, 0, -1);
        chk("badch_err", 64'(obs_err), 64'd1);
        run_cmd(1, 0, 0, 0, -1);
        chk("load_tap", 64'(tap_value[13:7]), 64'd0);
        chk("load_lat", 64'(obs_done_k), 64'd3);

        run_cmd(1, 3, 5, 0, -1);
        chk("set5_pulses", 64'(obs_pulses), 64'd5);
        chk("set5_period", 64'(obs_rise2 - obs_rise1), 64'd4);
        chk("set5_tap", 64'(tap_value[13:7]), 64'd5);
        chk("set5_err", 64'(obs_err), 64'd0);
        run_cmd(1, 3, 3, 0, -1);
        chk("set3_pulses", 64'(obs_pulses), 64'd2);
        chk("set3_tap", 64'(tap_value[13:7]), 64'd3);
        run_cmd(1, 3, 3, 0, -1);
        chk("set_eq_lat", 64'(obs_done_k), 64'd1);
        chk("set_eq_err", 64'(obs_err), 64'd0);

        run_cmd(3, 3, 100, 3, -1);
        chk("abort_err", 64'(obs_err), 64'd1);
        chk("abort_tap3", 64'(tap_value[27:21]), 64'd3);
        chk("abort_pulses", 64'(obs_pulses), 64'd3);

        run_cmd(2, 3, 50, 0, 6);
        chk("rst_taps", 64'(tap_value), 64'd0);
        run_cmd(0, 1, 0, 0, -1);
        chk("post_rst_inc", 64'(tap_value[6:0]), 64'd1);
        chk("post_rst_lat", 64'(obs_done_k), 64'd6);

        for (int it = 0; it < 60; it++) begin
            ch  = int'($urandom_range(0, 5));
            op  = int'($urandom_range(0, 3));
            cur = (ch < CH) ? int'(e_tap[ch]) : 0;
            case ($urandom_range(0, 9))
                0: val = 0;
                1: val = MAXT;
                default: val = cur + int'($urandom_range(0, 12)) - 6;
            endcase
            if (val < 0) val = 0;
            if (val > MAXT) val = MAXT;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : -1;
            run_cmd(ch, op, val, ab, ra);
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delayf_tap_ctrl.md
Name: delayf_tap_ctrl

Overview:
- Multi-channel sequencer that drives a bank of DELAYF-style delay cells (LOADN/MOVE/DIRECTION/CFLAG) from a simple command interface.
- Keeps a shadow tap count per channel so software and training logic can read the current delay.
- Adds absolute "set tap" moves, saturation checks, CFLAG abort and an automatic post-reset reload. A bare delay cell offers none of these.
- Sits between the I/O delay primitives and the read-leveling/training engine.

Parameters:
- CHANNELS, 4: number of delay cells controlled.
- TAP_W, 7: tap counter width; MAX_TAP = 2^TAP_W-1.
- INIT_TAP, 0: tap value the cells hold after LOADN (must match the cell DEL_VALUE).
- MOVE_HOLD, 2: cycles that MOVE and LOADN are held low/high per pulse (>=1).
- MOVE_GAP, 2: cycles MOVE is held low after each falling edge (>=1).
- CW, max(1,clog2(CHANNELS)): width of the channel select.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_chan  in  CW  target channel.
- cmd_op  in  2  00=LOAD, 01=INC, 10=DEC, 11=SET.
- cmd_value  in  TAP_W  target tap for SET.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: saturated, bad channel or CFLAG abort.
- busy  out  1  ~cmd_ready.
- tap_value  out  CHANNELS*TAP_W  shadow taps; channel i occupies bits [i*TAP_W +: TAP_W].
- loadn  out  CHANNELS  per-cell LOADN, active low.
- move  out  CHANNELS  per-cell MOVE.
- direction  out  CHANNELS  per-cell DIRECTION; 0 = increase delay, 1 = decrease.
- cflag  in  CHANNELS  per-cell CFLAG.

Behaviour:
- Interface: clock on clk, reset on rst; one clock domain; reset is synchronous and active-high.
- All outputs are registered.

Reset and initial load:
- While rst is high, outputs are: loadn all 1, move 0, direction 0, done 0, err 0, cmd_ready 0, every tap_value = INIT_TAP.
- FSM is forced to INIT.

FSM states: INIT, IDLE, LOAD, SETUP, MOVE_HI, MOVE_LO, DONE.
- INIT: loadn = all 0 for MOVE_HOLD cycles, then all 1, then IDLE. No done pulse.
- IDLE: cmd_ready = 1. A command is accepted on cmd_valid & cmd_ready, and chan/op/value are latched.
- Accepted command errors (go straight to DONE with err=1, no output activity):
  - cmd_chan >= CHANNELS;
  - INC with tap == MAX_TAP;
  - DEC with tap == 0;
  - SET with cmd_value == tap (err=0 in this case only).
- LOAD: loadn[chan] = 0 for MOVE_HOLD cycles, then DONE; tap[chan] <= INIT_TAP.
- SETUP (1 cycle): drive direction[chan] = (target < tap). Direction is held stable until DONE.
- MOVE_HI: move[chan] = 1 for MOVE_HOLD cycles.
- MOVE_LO: move[chan] = 0 for MOVE_GAP cycles. On entry (the MOVE falling edge), tap[chan] is incremented or decremented by 1.
- After MOVE_LO:
  - INC/DEC go to DONE.
  - SET returns to MOVE_HI while tap != target, else goes to DONE. SETUP is not repeated.
- CFLAG abort: if cflag[chan] is 1 on the last MOVE_LO cycle, go to DONE with err=1. tap keeps the completed steps.
- DONE: done=1 for one cycle, then IDLE. direction returns to 0.

Arithmetic and timing:
- Tap arithmetic is unsigned TAP_W bits and never wraps; the saturation checks guarantee this.
- Single-step latency: accept at t, done at t+2+MOVE_HOLD+MOVE_GAP.
- Pulse period for SET: MOVE_HOLD+MOVE_GAP cycles.
- Only the selected channel toggles; the other channels hold loadn=1, move=0, direction=0.
- rst mid-operation: move drops on the next cycle, the command is discarded with no done, and the INIT reload runs.

Test Plan:
(Defaults: CHANNELS=4, TAP_W=7, INIT_TAP=0, MOVE_HOLD=2, MOVE_GAP=2.)
1. Release rst → loadn=4'b0000 for exactly 2 cycles, cmd_ready=1 on the following cycle, all tap_value=0, no done pulse.
2. INC ch2 accepted at t → direction[2]=0, move[2] high at t+2..t+3, tap[2]=1 from t+4, done at t+6 with err=0; other channels are idle.
3. DEC ch0 at tap 0 → no move activity, done with err=1 at t+1, tap[0] stays 0. INC on ch1 preset to 127 gives the same result. cmd_chan=5 → err=1.
4. SET ch1 to 5 from 0 → 5 move pulses with a 4-cycle period, tap[1]=5, err=0. Then SET ch1 to 3 → direction[1]=1, 2 pulses, tap[1]=3.
5. SET ch3 to 100, with cflag[3] forced high after the 3rd pulse → aborts, done with err=1, tap[3]=3.
6. rst asserted during the MOVE_HI of a SET → move=0 next cycle, no done, INIT reload runs, all taps=0; a subsequent INC works normally.
